pmp_serial_checker: RTL

- Time-multiplexed PMP access checker: one region-evaluation datapath shared among PMPNumChan requesters (e.g. instruction and data channels).
- A round-robin arbiter accepts one request at a time. An FSM then scans regions 0..N-1, one per cycle, and returns the lowest-indexed match's verdict.
- Sits between the fetch/LSU request ports and the CSR-held pmpcfg/pmpaddr state. Trades latency for area against a fully parallel PMP.

---
 rtl/pmp_serial_checker_if.sv | 30 +++
 rtl/pmp_serial_checker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pmp_serial_checker_if.sv
// Request/response bundle between the fetch/LSU requesters and the serial PMP checker.
interface pmp_serial_checker_if #(
    parameter int unsigned NumChan    = 2,
    parameter int unsigned NumRegions = 4
);
    localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned RegW  = (NumRegions > 1) ? $clog2(NumRegions) : 1;

    logic [NumChan-1:0]      req_valid_i;
    logic [NumChan-1:0]      req_ready_o;
    logic [34*NumChan-1:0]   req_addr_i;
    logic [2*NumChan-1:0]    req_type_i;
    logic [2*NumChan-1:0]    priv_mode_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [ChanW-1:0]        rsp_chan_o;
    logic                    rsp_err_o;
    logic                    rsp_match_o;
    logic [RegW-1:0]         rsp_region_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_type_i, priv_mode_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_chan_o, rsp_err_o, rsp_match_o, rsp_region_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_type_i, priv_mode_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_chan_o, rsp_err_o, rsp_match_o, rsp_region_o
    );
endinterface

// File: rtl/pmp_serial_checker.sv
// Time-multiplexed PMP checker: round-robin accepts one request, then scans one region per
// cycle and reports the lowest-indexed matching region's verdict.
module pmp_serial_checker #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumChan     = 2,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [6*PMPNumRegions-1:0]  csr_pmp_cfg_i,
    input  logic [34*PMPNumRegions-1:0] csr_pmp_addr_i,
    pmp_serial_checker_if.slave         bus
);
    localparam int unsigned Lsb   = PMPGranularity + 2;
    localparam int unsigned AW    = 34 - Lsb;
    localparam int unsigned ChanW = (PMPNumChan > 1) ? $clog2(PMPNumChan) : 1;
    localparam int unsigned RegW  = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e            state_q, state_d;
    logic [ChanW-1:0]  rr_q, chan_q, grant_idx;
    logic [RegW-1:0]   region_q, hit_region_q;
    logic [AW-1:0]     addr_q;
    logic [1:0]        type_q, priv_q;
    logic              err_q, match_q;
    logic              grant_valid, accept;

    logic [AW-1:0]     cur_a, prev_a, mask;
    logic [5:0]        cur_cfg;
    logic              hit, perm, hit_err, last;

    // First valid channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned c;
        c           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < PMPNumChan; i++) begin
            c = (32'(rr_q) + i) % PMPNumChan;
            if (!grant_valid && bus.req_valid_i[c]) begin
                grant_valid = 1'b1;
                grant_idx   = ChanW'(c);
            end
        end
    end

    assign accept = (state_q == StIdle) && grant_valid;

    always_comb begin
        int unsigned idx;
        logic        napot, ones_run;
        idx      = 32'(region_q);
        cur_cfg  = csr_pmp_cfg_i[6*idx +: 6];
        cur_a    = csr_pmp_addr_i[34*idx + Lsb +: AW];
        prev_a   = (idx == 0) ? '0 : csr_pmp_addr_i[34*((idx == 0) ? 0 : idx - 1) + Lsb +: AW];
        napot    = (cur_cfg[4:3] == 2'b11);
        ones_run = 1'b1;
        mask     = '0;
        // A NAPOT mask drops bit b while every lower address bit is one.
        for (int unsigned j = 0; j < AW; j++) begin
            if (j > 0) ones_run = ones_run & cur_a[j-1];
            mask[j] = ~napot | ~ones_run;
        end
        case (cur_cfg[4:3])
            2'b00:   hit = 1'b0;
            2'b01:   hit = (addr_q >= prev_a) && (addr_q < cur_a);
            default: hit = ((addr_q ^ cur_a) & mask) == '0;
        endcase
        case (type_q)
            2'b00:   perm = cur_cfg[2];
            2'b01:   perm = cur_cfg[1];
            2'b10:   perm = cur_cfg[0];
            default: perm = 1'b0;
        endcase
        hit_err = (priv_q == 2'b11) ? (cur_cfg[5] & ~perm) : ~perm;
        last    = (region_q == RegW'(PMPNumRegions - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StScan;
            StScan:  if (hit || last) state_d = StResp;
            StResp:  if (bus.rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (accept) bus.req_ready_o[grant_idx] = 1'b1;
        bus.rsp_valid_o = (state_q == StResp);
    end

    assign bus.rsp_chan_o   = chan_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.rsp_match_o  = match_q;
    assign bus.rsp_region_o = hit_region_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            chan_q       <= '0;
            region_q     <= '0;
            hit_region_q <= '0;
            addr_q       <= '0;
            type_q       <= '0;
            priv_q       <= '0;
            err_q        <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= bus.req_addr_i[34*32'(grant_idx) + Lsb +: AW];
                type_q   <= bus.req_type_i[2*32'(grant_idx) +: 2];
                priv_q   <= bus.priv_mode_i[2*32'(grant_idx) +: 2];
                chan_q   <= grant_idx;
                rr_q     <= (grant_idx == ChanW'(PMPNumChan - 1)) ? '0 : grant_idx + 1'b1;
                region_q <= '0;
            end
            if (state_q == StScan) begin
                if (hit) begin
                    err_q        <= hit_err;
                    match_q      <= 1'b1;
                    hit_region_q <= region_q;
                end else if (last) begin
                    err_q        <= (priv_q != 2'b11);
                    match_q      <= 1'b0;
                    hit_region_q <= '0;
                end else begin
                    region_q <= region_q + 1'b1;
                end
            end
        end
    end
endmodule
